// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver FSM state type, the parity-mode encodings used by the
// PARITY_MODE parameter, and the parity-check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // data_xor is the reduction XOR of the data bits. Even parity expects the
  // total (data plus parity bit) to XOR to 0, odd parity expects 1.
  function automatic logic parity_err_f(input logic data_xor,
                                        input logic par_bit,
                                        input logic odd_mode);
    logic sum_s;
    sum_s = data_xor ^ par_bit;
    return odd_mode ? ~sum_s : sum_s;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk - clock; rst - async active-high reset (flops load RESET_VAL);
//        d - asynchronous input; q - synchronized output.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data bits, parity, stop bits) with a one-word
// holding register and valid/ready hand-off.
// Ports: clk, rst (async active-high); rx_serial_data - serial line, idles
//        high; rx_data/rx_data_valid/rx_data_ready - received word hand-off,
//        first received bit in rx_data[0]; parity_err/frame_err - status of the
//        held word; overrun - sticky, a frame was dropped while a word was
//        held; busy - receiver FSM not idle.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  logic                 rx_sync_s;
  uart_rx_state_t       state_r;
  uart_rx_state_t       state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic                 stop_idx_r;
  logic                 stop_bad_r;
  logic [DATA_BITS-1:0] data_sr_r;
  logic                 par_bit_r;
  logic                 cnt_clr_s;
  logic                 data_smp_s;
  logic                 par_smp_s;
  logic                 stop_smp_s;
  logic                 last_stop_s;
  logic                 accept_s;
  logic                 frame_err_nx_s;
  logic                 parity_err_nx_s;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_data_valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial_data),
    .q   (rx_sync_s)
  );

  // Next-state decode and per-state sample strobes
  always_comb begin
    state_nx_s  = state_r;
    cnt_clr_s   = 1'b0;
    data_smp_s  = 1'b0;
    par_smp_s   = 1'b0;
    stop_smp_s  = 1'b0;
    last_stop_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_clr_s = 1'b1;
        if (!rx_sync_s) begin
          state_nx_s = S_START;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_START: begin
        // Mid-start-bit check: a line back high here was only a glitch
        if (cnt_r == CNT_HALF) begin
          cnt_clr_s  = 1'b1;
          state_nx_s = rx_sync_s ? S_IDLE : S_DATA;
        end else begin
          state_nx_s = S_START;
        end
      end
      S_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_clr_s  = 1'b1;
          data_smp_s = 1'b1;
          if (bit_idx_r == IDX_LAST) begin
            state_nx_s = (PARITY_MODE == PARITY_NONE) ? S_STOP : S_PARITY;
          end else begin
            state_nx_s = S_DATA;
          end
        end else begin
          state_nx_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          cnt_clr_s  = 1'b1;
          par_smp_s  = 1'b1;
          state_nx_s = S_STOP;
        end else begin
          state_nx_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_clr_s  = 1'b1;
          stop_smp_s = 1'b1;
          if (stop_idx_r == STOP_LAST) begin
            last_stop_s = 1'b1;
            state_nx_s  = S_IDLE;
          end else begin
            state_nx_s = S_STOP;
          end
        end else begin
          state_nx_s = S_STOP;
        end
      end
      default: begin
        cnt_clr_s  = 1'b1;
        state_nx_s = S_IDLE;
      end
    endcase
  end

  assign accept_s       = rx_data_valid_r & rx_data_ready;
  // Includes the stop bit being sampled this cycle
  assign frame_err_nx_s = stop_bad_r | ~rx_sync_s;
  assign parity_err_nx_s = (PARITY_MODE == PARITY_NONE) ? 1'b0 :
                           parity_err_f(^data_sr_r, par_bit_r, (PARITY_MODE == PARITY_ODD));

  // FSM state, bit-period counter and frame assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      bit_idx_r  <= {IDX_W{1'b0}};
      stop_idx_r <= 1'b0;
      stop_bad_r <= 1'b0;
      data_sr_r  <= {DATA_BITS{1'b0}};
      par_bit_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != S_IDLE);
      if (cnt_clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (state_r == S_START) begin
        bit_idx_r  <= {IDX_W{1'b0}};
        stop_idx_r <= 1'b0;
        stop_bad_r <= 1'b0;
      end else begin
        // Shift in from the top so the first bit ends up in bit 0
        if (data_smp_s) begin
          data_sr_r <= {rx_sync_s, data_sr_r[DATA_BITS-1:1]};
          bit_idx_r <= bit_idx_r + IDX_ONE;
        end
        if (par_smp_s) begin
          par_bit_r <= rx_sync_s;
        end
        if (stop_smp_s) begin
          stop_idx_r <= stop_idx_r + 1'b1;
          stop_bad_r <= frame_err_nx_s;
        end
      end
    end
  end

  // Holding register hand-off, error flags and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r       <= {DATA_BITS{1'b0}};
      rx_data_valid_r <= 1'b0;
      parity_err_r    <= 1'b0;
      frame_err_r     <= 1'b0;
      overrun_r       <= 1'b0;
    end else if (last_stop_s && (!rx_data_valid_r || accept_s)) begin
      // Free slot, or the held word is taken this same cycle
      rx_data_r       <= data_sr_r;
      rx_data_valid_r <= 1'b1;
      parity_err_r    <= parity_err_nx_s;
      frame_err_r     <= frame_err_nx_s;
      overrun_r       <= 1'b0;
    end else if (last_stop_s) begin
      overrun_r <= 1'b1;
    end else if (accept_s) begin
      rx_data_valid_r <= 1'b0;
      overrun_r       <= 1'b0;
    end
  end

  assign rx_data       = rx_data_r;
  assign rx_data_valid = rx_data_valid_r;
  assign parity_err    = parity_err_r;
  assign frame_err     = frame_err_r;
  assign overrun       = overrun_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at 16 clocks per bit. Four instances cover
// 8N1, 8E1, 8O1 and 8N2; only one serial line toggles at a time.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ln;
  logic [3:0] rdy;
  logic [7:0] rxd [4];
  logic [3:0] vld, perr, ferr, ovr, bsy;

  int         vcnt  [4] = '{default: 0};
  logic [7:0] cap_d [4] = '{default: 8'h00};
  logic       cap_p [4] = '{default: 1'b0};
  logic       cap_f [4] = '{default: 1'b0};

  int total = 0;
  int bad   = 0;
  int v0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .rx_serial_data(ln[0]), .rx_data(rxd[0]), .rx_data_valid(vld[0]),
    .rx_data_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .rx_serial_data(ln[1]), .rx_data(rxd[1]), .rx_data_valid(vld[1]),
    .rx_data_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst(rst), .rx_serial_data(ln[2]), .rx_data(rxd[2]), .rx_data_valid(vld[2]),
    .rx_data_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .rx_serial_data(ln[3]), .rx_data(rxd[3]), .rx_data_valid(vld[3]),
    .rx_data_ready(rdy[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]), .busy(bsy[3]));

  // Count valid cycles and capture the delivered word per instance
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) begin
        vcnt[i]  = vcnt[i] + 1;
        cap_d[i] = rxd[i];
        cap_p[i] = perr[i];
        cap_f[i] = ferr[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int ch, input logic b);
    ln[ch] = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits
  task automatic send_frame(input int ch, input logic [7:0] data, input bit has_par,
                            input logic pbit, input int nstop, input logic s0, input logic s1);
    send_bit(ch, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(ch, data[i]);
    if (has_par) send_bit(ch, pbit);
    send_bit(ch, s0);
    if (nstop == 2) send_bit(ch, s1);
    ln[ch] = 1'b1;
  endtask

  initial begin
    logic [7:0] d22;
    ln  = 4'hF;
    rdy = 4'hF;
    rst = 1'b1;
    idle(3);
    check("rst_valid", {31'd0, vld[0]}, 32'd0);
    check("rst_busy",  {31'd0, bsy[0]}, 32'd0);
    check("rst_data",  {24'd0, rxd[0]}, 32'd0);
    check("rst_ovr",   {31'd0, ovr[0]}, 32'd0);
    rst = 1'b0;
    idle(8);

    // 8N1 0xA5, ready held high: single valid pulse, clean flags
    v0 = vcnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(32);
    check("n1_data",  {24'd0, cap_d[0]}, 32'h0000_00A5);
    check("n1_pulse", vcnt[0] - v0, 32'd1);
    check("n1_ferr",  {31'd0, cap_f[0]}, 32'd0);
    check("n1_perr",  {31'd0, cap_p[0]}, 32'd0);
    check("n1_vlow",  {31'd0, vld[0]}, 32'd0);

    // 8E1 0x07 (three ones): parity bit 0 is wrong, 1 is right
    send_frame(1, 8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    idle(32);
    check("e1_data", {24'd0, cap_d[1]}, 32'h0000_0007);
    check("e1_perr_bad", {31'd0, cap_p[1]}, 32'd1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    idle(32);
    check("e1_perr_good", {31'd0, cap_p[1]}, 32'd0);

    // 8O1 0x07: parity bit 0 is right, 1 is wrong
    send_frame(2, 8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    idle(32);
    check("o1_data", {24'd0, cap_d[2]}, 32'h0000_0007);
    check("o1_perr_good", {31'd0, cap_p[2]}, 32'd0);
    send_frame(2, 8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    idle(32);
    check("o1_perr_bad", {31'd0, cap_p[2]}, 32'd1);

    // 5-clock low glitch on the 8N1 line: busy briefly, no word
    v0 = vcnt[0];
    ln[0] = 1'b0;
    idle(4);
    check("glitch_busy", {31'd0, bsy[0]}, 32'd1);
    idle(1);
    ln[0] = 1'b1;
    idle(16);
    check("glitch_idle", {31'd0, bsy[0]}, 32'd0);
    check("glitch_novalid", vcnt[0] - v0, 32'd0);

    // Three back-to-back frames with ready low: first word held, overrun set
    rdy[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(32);
    check("ovr_data",  {24'd0, rxd[0]}, 32'h0000_0011);
    check("ovr_valid", {31'd0, vld[0]}, 32'd1);
    check("ovr_flag",  {31'd0, ovr[0]}, 32'd1);
    rdy[0] = 1'b1;
    idle(1);
    rdy[0] = 1'b0;
    check("ovr_acc_valid", {31'd0, vld[0]}, 32'd0);
    check("ovr_acc_flag",  {31'd0, ovr[0]}, 32'd0);

    // Accept lands exactly on the last stop sample: new word loads, no overrun
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(16);
    check("coin_held", {24'd0, rxd[0]}, 32'h0000_0011);
    d22 = 8'h22;
    send_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(0, d22[i]);
    ln[0] = 1'b1;
    idle(11);
    rdy[0] = 1'b1;
    idle(1);
    rdy[0] = 1'b0;
    check("coin_valid", {31'd0, vld[0]}, 32'd1);
    check("coin_data",  {24'd0, rxd[0]}, 32'h0000_0022);
    check("coin_ovr",   {31'd0, ovr[0]}, 32'd0);
    idle(5);
    rdy[0] = 1'b1;
    idle(4);
    check("coin_drain", {31'd0, vld[0]}, 32'd0);

    // 8N2: bad second stop bit, then a break, then a clean frame
    send_frame(3, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    idle(32);
    check("n2_data", {24'd0, cap_d[3]}, 32'h0000_003C);
    check("n2_ferr", {31'd0, cap_f[3]}, 32'd1);
    v0 = vcnt[3];
    send_frame(3, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    idle(32);
    check("brk_data", {24'd0, cap_d[3]}, 32'd0);
    check("brk_ferr", {31'd0, cap_f[3]}, 32'd1);
    check("brk_pulse", vcnt[3] - v0, 32'd1);
    send_frame(3, 8'h81, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    idle(32);
    check("n2_good_data", {24'd0, cap_d[3]}, 32'h0000_0081);
    check("n2_good_ferr", {31'd0, cap_f[3]}, 32'd0);

    // Reset in the middle of the data bits of 0x5A, then a clean 0xC3
    v0 = vcnt[0];
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    check("mid_busy", {31'd0, bsy[0]}, 32'd1);
    rst = 1'b1;
    idle(1);
    check("mid_rst_busy",  {31'd0, bsy[0]}, 32'd0);
    check("mid_rst_valid", {31'd0, vld[0]}, 32'd0);
    check("mid_rst_data",  {24'd0, rxd[0]}, 32'd0);
    check("mid_rst_ferr",  {31'd0, ferr[0]}, 32'd0);
    ln[0] = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(48);
    check("post_rst_idle", {31'd0, bsy[0]}, 32'd0);
    check("post_rst_novalid", vcnt[0] - v0, 32'd0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(32);
    check("post_rst_data",  {24'd0, cap_d[0]}, 32'h0000_00C3);
    check("post_rst_pulse", vcnt[0] - v0, 32'd1);
    check("post_rst_ferr",  {31'd0, cap_f[0]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
